// File: rtl/max_reduce_pipe.sv
// max_reduce_pipe: pipelined binary max tree feeding a per-sequence running maximum.
// Optional argmax tracking (lane, beat) is enabled by defining MAX_REDUCE_ARGMAX_EN.
module max_reduce_pipe #(
  parameter int DATA_WIDTH    = 16,
  parameter int N_IN          = 64,
  parameter int LVL_PER_STAGE = 3,
  parameter int BEAT_W        = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic [DATA_WIDTH*N_IN-1:0] in_data,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_max,
  output logic [$clog2(N_IN)-1:0]    out_lane,
  output logic [BEAT_W-1:0]          out_beat
);

  localparam int LANE_W = $clog2(N_IN);
  localparam int L      = LANE_W;
  localparam int NODES  = 2 * N_IN - 1;
  localparam int MSB    = DATA_WIDTH - 1;

  // Tree levels are packed back to back in one node array; level lvl starts here.
  function automatic int lvl_off(input int lvl);
    return (2 * N_IN) - ((2 * N_IN) >> lvl);
  endfunction

  function automatic logic b_wins(input logic [DATA_WIDTH-1:0] a,
                                  input logic [DATA_WIDTH-1:0] b);
    logic w;
    if (!a[MSB] && !b[MSB]) begin
      w = (b > a);
    end else if (a[MSB] && !b[MSB]) begin
      w = 1'b1;
    end else begin
      w = 1'b0;
    end
    return w;
  endfunction

  // Two negatives collapse to zero, so every value above level 0 is non-negative.
  function automatic logic [DATA_WIDTH-1:0] pick_val(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] r;
    if (a[MSB] && b[MSB]) begin
      r = {DATA_WIDTH{1'b0}};
    end else if (b_wins(a, b)) begin
      r = b;
    end else begin
      r = a;
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] node_val [NODES];
  logic                  node_v   [L+1];
  logic                  node_f   [L+1];
  logic                  node_l   [L+1];
`ifdef MAX_REDUCE_ARGMAX_EN
  logic [LANE_W-1:0]     node_lane [NODES];
`endif

  genvar gi, lv, gj;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_leaf
      assign node_val[gi] = in_data[DATA_WIDTH*gi +: DATA_WIDTH];
`ifdef MAX_REDUCE_ARGMAX_EN
      assign node_lane[gi] = LANE_W'(gi);
`endif
    end

    for (lv = 1; lv <= L; lv++) begin : g_lvl
      localparam int CNT    = N_IN >> lv;
      localparam int PO     = lvl_off(lv - 1);
      localparam int CO     = lvl_off(lv);
      localparam bit IS_REG = ((lv % LVL_PER_STAGE) == 0) || (lv == L);

      logic [DATA_WIDTH-1:0] val_d [CNT];
`ifdef MAX_REDUCE_ARGMAX_EN
      logic [LANE_W-1:0]     lane_d [CNT];
`endif

      for (gj = 0; gj < CNT; gj++) begin : g_node
        assign val_d[gj] = pick_val(node_val[PO+2*gj], node_val[PO+2*gj+1]);
`ifdef MAX_REDUCE_ARGMAX_EN
        assign lane_d[gj] = b_wins(node_val[PO+2*gj], node_val[PO+2*gj+1]) ?
                            node_lane[PO+2*gj+1] : node_lane[PO+2*gj];
`endif
      end

      if (IS_REG) begin : g_reg
        logic [DATA_WIDTH-1:0] val_q [CNT];
        logic                  v_q;
        logic                  f_q;
        logic                  l_q;
`ifdef MAX_REDUCE_ARGMAX_EN
        logic [LANE_W-1:0]     lane_q [CNT];
`endif

        // Pipeline register closing this group of tree levels.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int k = 0; k < CNT; k++) begin
              val_q[k] <= {DATA_WIDTH{1'b0}};
`ifdef MAX_REDUCE_ARGMAX_EN
              lane_q[k] <= {LANE_W{1'b0}};
`endif
            end
            v_q <= 1'b0;
            f_q <= 1'b0;
            l_q <= 1'b0;
          end else begin
            val_q <= val_d;
`ifdef MAX_REDUCE_ARGMAX_EN
            lane_q <= lane_d;
`endif
            v_q <= node_v[lv-1];
            f_q <= node_f[lv-1];
            l_q <= node_l[lv-1];
          end
        end

        for (gj = 0; gj < CNT; gj++) begin : g_out
          assign node_val[CO+gj] = val_q[gj];
`ifdef MAX_REDUCE_ARGMAX_EN
          assign node_lane[CO+gj] = lane_q[gj];
`endif
        end
        assign node_v[lv] = v_q;
        assign node_f[lv] = f_q;
        assign node_l[lv] = l_q;
      end else begin : g_comb
        for (gj = 0; gj < CNT; gj++) begin : g_out
          assign node_val[CO+gj] = val_d[gj];
`ifdef MAX_REDUCE_ARGMAX_EN
          assign node_lane[CO+gj] = lane_d[gj];
`endif
        end
        assign node_v[lv] = node_v[lv-1];
        assign node_f[lv] = node_f[lv-1];
        assign node_l[lv] = node_l[lv-1];
      end
    end
  endgenerate

  assign node_v[0] = in_valid;
  assign node_f[0] = in_first;
  assign node_l[0] = in_last;

  logic [DATA_WIDTH-1:0] top_val;
  logic                  top_v;
  logic                  top_f;
  logic                  top_l;
  logic                  top_wins;
  assign top_val = node_val[NODES-1];
  assign top_v   = node_v[L];
  assign top_f   = node_f[L];
  assign top_l   = node_l[L];

  logic [DATA_WIDTH-1:0] acc_max_q, acc_max_d;
  logic                  done_q, done_d;
`ifdef MAX_REDUCE_ARGMAX_EN
  logic [LANE_W-1:0]     top_lane;
  logic [LANE_W-1:0]     acc_lane_q, acc_lane_d;
  logic [BEAT_W-1:0]     acc_beat_q, acc_beat_d;
  logic [BEAT_W-1:0]     cnt_q, cnt_d;
  assign top_lane = node_lane[NODES-1];
`endif

  // Accumulator is always non-negative, and a tie keeps the earlier beat.
  assign top_wins = b_wins(acc_max_q, top_val);

  // Accumulator next state: restart on first, fold otherwise, flag completion on last.
  always_comb begin
    acc_max_d = acc_max_q;
    done_d    = 1'b0;
`ifdef MAX_REDUCE_ARGMAX_EN
    acc_lane_d = acc_lane_q;
    acc_beat_d = acc_beat_q;
    cnt_d      = cnt_q;
`endif
    if (top_v) begin
      done_d = top_l;
      if (top_f) begin
        acc_max_d = top_val;
`ifdef MAX_REDUCE_ARGMAX_EN
        acc_lane_d = top_lane;
        acc_beat_d = {BEAT_W{1'b0}};
        cnt_d      = BEAT_W'(1);
`endif
      end else begin
        if (top_wins) begin
          acc_max_d = top_val;
`ifdef MAX_REDUCE_ARGMAX_EN
          acc_lane_d = top_lane;
          acc_beat_d = cnt_q;
`endif
        end else begin
          acc_max_d = acc_max_q;
        end
`ifdef MAX_REDUCE_ARGMAX_EN
        if (cnt_q != {BEAT_W{1'b1}}) begin
          cnt_d = cnt_q + BEAT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
`endif
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // Accumulator state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_max_q <= {DATA_WIDTH{1'b0}};
      done_q    <= 1'b0;
`ifdef MAX_REDUCE_ARGMAX_EN
      acc_lane_q <= {LANE_W{1'b0}};
      acc_beat_q <= {BEAT_W{1'b0}};
      cnt_q      <= {BEAT_W{1'b0}};
`endif
    end else begin
      acc_max_q <= acc_max_d;
      done_q    <= done_d;
`ifdef MAX_REDUCE_ARGMAX_EN
      acc_lane_q <= acc_lane_d;
      acc_beat_q <= acc_beat_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_max_q, out_max_d;
`ifdef MAX_REDUCE_ARGMAX_EN
  logic [LANE_W-1:0]     out_lane_q, out_lane_d;
  logic [BEAT_W-1:0]     out_beat_q, out_beat_d;
`endif

  // Result holding stage: capture the completed sequence, hold until the next one.
  always_comb begin
    out_valid_d = done_q;
    out_max_d   = out_max_q;
`ifdef MAX_REDUCE_ARGMAX_EN
    out_lane_d  = out_lane_q;
    out_beat_d  = out_beat_q;
`endif
    if (done_q) begin
      out_max_d = acc_max_q;
`ifdef MAX_REDUCE_ARGMAX_EN
      out_lane_d = acc_lane_q;
      out_beat_d = acc_beat_q;
`endif
    end else begin
      out_max_d = out_max_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_max_q   <= {DATA_WIDTH{1'b0}};
`ifdef MAX_REDUCE_ARGMAX_EN
      out_lane_q  <= {LANE_W{1'b0}};
      out_beat_q  <= {BEAT_W{1'b0}};
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_max_q   <= out_max_d;
`ifdef MAX_REDUCE_ARGMAX_EN
      out_lane_q  <= out_lane_d;
      out_beat_q  <= out_beat_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_max   = out_max_q;
`ifdef MAX_REDUCE_ARGMAX_EN
  assign out_lane  = out_lane_q;
  assign out_beat  = out_beat_q;
`else
  assign out_lane  = {LANE_W{1'b0}};
  assign out_beat  = {BEAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_max_reduce_pipe.sv
// Self-checking bench for max_reduce_pipe: directed vectors plus randomized sequences
// against a clamp-and-argmax reference model; a second small instance checks S=3 latency.
module tb_max_reduce_pipe;

  localparam int DW  = 16;
  localparam int N   = 64;
  localparam int BW  = 8;
  localparam int S   = 2;
  localparam int N2  = 8;
  localparam int S2  = 3;
`ifdef MAX_REDUCE_ARGMAX_EN
  localparam bit ARGMAX = 1'b1;
`else
  localparam bit ARGMAX = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            in_valid, in_first, in_last;
  logic [DW*N-1:0] in_data;
  logic            out_valid;
  logic [DW-1:0]   out_max;
  logic [5:0]      out_lane;
  logic [BW-1:0]   out_beat;

  logic             in2_valid, in2_first, in2_last;
  logic [DW*N2-1:0] in2_data;
  logic             out2_valid;
  logic [DW-1:0]    out2_max;
  logic [2:0]       out2_lane;
  logic [BW-1:0]    out2_beat;

  max_reduce_pipe #(.DATA_WIDTH(DW), .N_IN(N), .LVL_PER_STAGE(3), .BEAT_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .in_data(in_data), .out_valid(out_valid), .out_max(out_max), .out_lane(out_lane),
    .out_beat(out_beat));

  max_reduce_pipe #(.DATA_WIDTH(DW), .N_IN(N2), .LVL_PER_STAGE(1), .BEAT_W(BW)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in2_valid), .in_first(in2_first), .in_last(in2_last),
    .in_data(in2_data), .out_valid(out2_valid), .out_max(out2_max), .out_lane(out2_lane),
    .out_beat(out2_beat));

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int rec_cyc[$], rec_max[$], rec_lane[$], rec_beat[$];
  int exp_cyc[$], exp_max[$], exp_lane[$], exp_beat[$];
  int rec2_cyc[$], rec2_max[$];
  int mv, ml, mb, mc;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result pulse with the edge number that raised it.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      rec_cyc.push_back(cyc);
      rec_max.push_back(int'(out_max));
      rec_lane.push_back(int'(out_lane));
      rec_beat.push_back(int'(out_beat));
    end
    if (out2_valid === 1'b1) begin
      rec2_cyc.push_back(cyc);
      rec2_max.push_back(int'(out2_max));
    end
  end

  function automatic int clampv(input logic [DW-1:0] x);
    return x[DW-1] ? 0 : int'(x);
  endfunction

  function automatic logic [DW*N-1:0] fill(input logic [DW-1:0] v);
    logic [DW*N-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = v;
    return d;
  endfunction

  function automatic logic [DW*N-1:0] rand_beat();
    logic [DW*N-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom_range(1, 65535));
    return d;
  endfunction

  task automatic model_clear();
    mv = 0; ml = 0; mb = 0; mc = 0;
  endtask

  task automatic clear_q();
    rec_cyc.delete(); rec_max.delete(); rec_lane.delete(); rec_beat.delete();
    exp_cyc.delete(); exp_max.delete(); exp_lane.delete(); exp_beat.delete();
    rec2_cyc.delete(); rec2_max.delete();
  endtask

  // Drive one beat and advance the reference model: clamped max, lowest lane, earliest beat.
  task automatic drive_beat(input bit f, input bit l, input logic [DW*N-1:0] d);
    int bv, bl, x;
    @(negedge clk);
    in_valid = 1'b1; in_first = f; in_last = l; in_data = d;
    bv = -1; bl = 0;
    for (int i = 0; i < N; i++) begin
      x = clampv(d[i*DW +: DW]);
      if (x > bv) begin bv = x; bl = i; end
    end
    if (f) begin
      mv = bv; ml = bl; mb = 0; mc = 1;
    end else begin
      if (bv > mv) begin mv = bv; ml = bl; mb = mc; end
      if (mc < 255) mc++;
    end
    if (l) begin
      exp_cyc.push_back(cyc + 1 + S + 1);
      exp_max.push_back(mv);
      exp_lane.push_back(ARGMAX ? ml : 0);
      exp_beat.push_back(ARGMAX ? mb : 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = '0;
    in2_valid = 1'b0; in2_first = 1'b0; in2_last = 1'b0; in2_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_max !== 16'd0) begin n_fail++; $display("FAIL reset_max: got %0d expected 0", out_max); end
    n_cmp++; if (out_lane !== 6'd0) begin n_fail++; $display("FAIL reset_lane: got %0d expected 0", out_lane); end
    n_cmp++; if (out_beat !== 8'd0) begin n_fail++; $display("FAIL reset_beat: got %0d expected 0", out_beat); end
    n_cmp++; if (out2_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid2: got %b expected 0", out2_valid); end
    rst_n = 1'b1;
    model_clear();
    clear_q();
    idle(2);
  endtask

  task automatic test_single_beat();
    logic [DW*N-1:0] d;
    int k;
    clear_q();
    d = fill(16'd100);
    d[37*DW +: DW] = 16'd500;
    drive_beat(1'b1, 1'b1, d);
    k = cyc + 1;
    idle(S + 3);
    n_cmp++; if (rec_cyc.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", rec_cyc.size()); end
    n_cmp++; if (rec_cyc[0] != k + 3) begin n_fail++; $display("FAIL single_latency: got edge %0d expected %0d", rec_cyc[0], k + 3); end
    n_cmp++; if (rec_max[0] != 500) begin n_fail++; $display("FAIL single_max: got %0d expected 500", rec_max[0]); end
    n_cmp++; if (rec_lane[0] != (ARGMAX ? 37 : 0)) begin n_fail++; $display("FAIL single_lane: got %0d expected %0d", rec_lane[0], ARGMAX ? 37 : 0); end
    n_cmp++; if (rec_beat[0] != 0) begin n_fail++; $display("FAIL single_beat: got %0d expected 0", rec_beat[0]); end
  endtask

  task automatic test_four_beat();
    logic [DW*N-1:0] d;
    clear_q();
    d = fill(16'hFFF0); d[5*DW +: DW]  = 16'd20; drive_beat(1'b1, 1'b0, d);
    d = fill(16'hFFF0); d[12*DW +: DW] = 16'd90; drive_beat(1'b0, 1'b0, d);
    d = fill(16'hFFF0); d[3*DW +: DW]  = 16'd90; drive_beat(1'b0, 1'b0, d);
    d = fill(16'hFFF0); d[0*DW +: DW]  = 16'd40; drive_beat(1'b0, 1'b1, d);
    idle(S + 3);
    n_cmp++; if (rec_cyc.size() != 1) begin n_fail++; $display("FAIL four_count: got %0d expected 1", rec_cyc.size()); end
    n_cmp++; if (rec_max[0] != 90) begin n_fail++; $display("FAIL four_max: got %0d expected 90", rec_max[0]); end
    n_cmp++; if (rec_lane[0] != (ARGMAX ? 12 : 0)) begin n_fail++; $display("FAIL four_lane: got %0d expected %0d", rec_lane[0], ARGMAX ? 12 : 0); end
    n_cmp++; if (rec_beat[0] != (ARGMAX ? 1 : 0)) begin n_fail++; $display("FAIL four_beat: got %0d expected %0d", rec_beat[0], ARGMAX ? 1 : 0); end
  endtask

  task automatic test_all_negative();
    clear_q();
    drive_beat(1'b1, 1'b1, fill(16'h8005));
    idle(S + 3);
    n_cmp++; if (rec_max.size() != 1 || rec_max[0] != 0) begin n_fail++; $display("FAIL neg_max: got %0d expected 0", rec_max[0]); end
    n_cmp++; if (rec_lane[0] != 0) begin n_fail++; $display("FAIL neg_lane: got %0d expected 0", rec_lane[0]); end
  endtask

  task automatic test_tie_lanes();
    logic [DW*N-1:0] d;
    clear_q();
    d = fill(16'd7);
    d[10*DW +: DW] = 16'd300;
    d[11*DW +: DW] = 16'd300;
    drive_beat(1'b1, 1'b1, d);
    idle(S + 3);
    n_cmp++; if (rec_max.size() != 1 || rec_max[0] != 300) begin n_fail++; $display("FAIL tie_max: got %0d expected 300", rec_max[0]); end
    n_cmp++; if (rec_lane[0] != (ARGMAX ? 10 : 0)) begin n_fail++; $display("FAIL tie_lane: got %0d expected %0d", rec_lane[0], ARGMAX ? 10 : 0); end
  endtask

  task automatic test_back_to_back();
    clear_q();
    for (int b = 0; b < 3; b++) drive_beat(b == 0, b == 2, rand_beat());
    for (int b = 0; b < 5; b++) drive_beat(b == 0, b == 4, rand_beat());
    idle(S + 4);
    n_cmp++; if (rec_cyc.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", rec_cyc.size()); end
    n_cmp++; if (rec_cyc[1] - rec_cyc[0] != 5) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 5", rec_cyc[1] - rec_cyc[0]); end
    for (int i = 0; i < 2 && i < rec_cyc.size(); i++) begin
      n_cmp++; if (rec_cyc[i] != exp_cyc[i]) begin n_fail++; $display("FAIL b2b_edge[%0d]: got %0d expected %0d", i, rec_cyc[i], exp_cyc[i]); end
      n_cmp++; if (rec_max[i] != exp_max[i]) begin n_fail++; $display("FAIL b2b_max[%0d]: got %0d expected %0d", i, rec_max[i], exp_max[i]); end
      n_cmp++; if (rec_lane[i] != exp_lane[i]) begin n_fail++; $display("FAIL b2b_lane[%0d]: got %0d expected %0d", i, rec_lane[i], exp_lane[i]); end
      n_cmp++; if (rec_beat[i] != exp_beat[i]) begin n_fail++; $display("FAIL b2b_beat[%0d]: got %0d expected %0d", i, rec_beat[i], exp_beat[i]); end
    end
  endtask

  // Random sequences with bubbles and occasional abandonment by a fresh first beat.
  task automatic test_random();
    int len;
    bit abandon;
    clear_q();
    for (int s = 0; s < 40; s++) begin
      len = $urandom_range(1, 6);
      abandon = ($urandom_range(0, 4) == 0);
      for (int b = 0; b < len; b++) begin
        drive_beat(b == 0, (b == len - 1) && !abandon, rand_beat());
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    drive_beat(1'b1, 1'b1, rand_beat());
    idle(S + 4);
    n_cmp++; if (rec_cyc.size() != exp_cyc.size()) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", rec_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size() && i < rec_cyc.size(); i++) begin
      n_cmp++; if (rec_cyc[i] != exp_cyc[i]) begin n_fail++; $display("FAIL rand_edge[%0d]: got %0d expected %0d", i, rec_cyc[i], exp_cyc[i]); end
      n_cmp++; if (rec_max[i] != exp_max[i]) begin n_fail++; $display("FAIL rand_max[%0d]: got %0d expected %0d", i, rec_max[i], exp_max[i]); end
      n_cmp++; if (rec_lane[i] != exp_lane[i]) begin n_fail++; $display("FAIL rand_lane[%0d]: got %0d expected %0d", i, rec_lane[i], exp_lane[i]); end
      n_cmp++; if (rec_beat[i] != exp_beat[i]) begin n_fail++; $display("FAIL rand_beat[%0d]: got %0d expected %0d", i, rec_beat[i], exp_beat[i]); end
    end
  endtask

  // 300 rising beats: the beat counter saturates, so the winner reports beat 255.
  task automatic test_saturate();
    logic [DW*N-1:0] d;
    clear_q();
    for (int b = 0; b < 300; b++) begin
      d = fill(16'hFFFF);
      d[0 +: DW] = DW'(b + 1);
      drive_beat(b == 0, b == 299, d);
    end
    idle(S + 3);
    n_cmp++; if (rec_max.size() != 1 || rec_max[0] != 300) begin n_fail++; $display("FAIL sat_max: got %0d expected 300", rec_max[0]); end
    n_cmp++; if (rec_beat[0] != (ARGMAX ? 255 : 0)) begin n_fail++; $display("FAIL sat_beat: got %0d expected %0d", rec_beat[0], ARGMAX ? 255 : 0); end
  endtask

  task automatic test_reset_midseq();
    logic [DW*N-1:0] d;
    int k;
    clear_q();
    drive_beat(1'b1, 1'b0, rand_beat());
    drive_beat(1'b0, 1'b0, rand_beat());
    drive_beat(1'b0, 1'b1, rand_beat());
    @(negedge clk);
    #1 rst_n = 1'b0;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    #1;
    n_cmp++; if (out_max !== 16'd0) begin n_fail++; $display("FAIL rstmid_max: got %0d expected 0", out_max); end
    n_cmp++; if (out_beat !== 8'd0) begin n_fail++; $display("FAIL rstmid_beat: got %0d expected 0", out_beat); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    clear_q();
    idle(S + 3);
    n_cmp++; if (rec_cyc.size() != 0) begin n_fail++; $display("FAIL rstmid_dropped: got %0d pulses expected 0", rec_cyc.size()); end
    // After reset the accumulator starts at zero even without a first beat.
    d = fill(16'h8001);
    d[2*DW +: DW] = 16'd50;
    drive_beat(1'b0, 1'b1, d);
    k = cyc + 1;
    idle(S + 3);
    n_cmp++; if (rec_cyc.size() != 1 || rec_cyc[0] != k + 3) begin n_fail++; $display("FAIL nofirst_edge: got %0d expected %0d", rec_cyc[0], k + 3); end
    n_cmp++; if (rec_max[0] != 50) begin n_fail++; $display("FAIL nofirst_max: got %0d expected 50", rec_max[0]); end
    n_cmp++; if (rec_lane[0] != (ARGMAX ? 2 : 0)) begin n_fail++; $display("FAIL nofirst_lane: got %0d expected %0d", rec_lane[0], ARGMAX ? 2 : 0); end
  endtask

  task automatic test_small_pipe();
    int k, bv;
    for (int t = 0; t < 3; t++) begin
      clear_q();
      @(negedge clk);
      for (int i = 0; i < N2; i++) in2_data[i*DW +: DW] = DW'($urandom_range(1, 65535));
      in2_valid = 1'b1; in2_first = 1'b1; in2_last = 1'b1;
      k = cyc + 1;
      bv = 0;
      for (int i = 0; i < N2; i++) if (clampv(in2_data[i*DW +: DW]) > bv) bv = clampv(in2_data[i*DW +: DW]);
      @(negedge clk);
      in2_valid = 1'b0; in2_first = 1'b0; in2_last = 1'b0;
      repeat (S2 + 3) @(negedge clk);
      n_cmp++; if (rec2_cyc.size() != 1 || rec2_cyc[0] != k + 4) begin n_fail++; $display("FAIL small_latency: got %0d expected %0d", rec2_cyc[0], k + 4); end
      n_cmp++; if (rec2_max[0] != bv) begin n_fail++; $display("FAIL small_max: got %0d expected %0d", rec2_max[0], bv); end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_four_beat();
    test_all_negative();
    test_tie_lanes();
    test_back_to_back();
    test_random();
    test_saturate();
    test_reset_midseq();
    test_small_pipe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
